// File: rtl/adder_issue_ctrl_pkg.sv
// Shared constants and response payload for the adder issue/response control stage.
package adder_issue_ctrl_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADD_LAT_DEF = 2;
  localparam int unsigned TAG_W_DEF   = 4;

  typedef struct packed {
    logic [DATA_W-1:0]    sum;
    logic [TAG_W_DEF-1:0] tag;
  } rsp_t;

endpackage

// File: rtl/adder_issue_ctrl_if.sv
// Request, adder hookup and response signals of the adder issue control stage.
interface adder_issue_ctrl_if
  import adder_issue_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] add_in1;
  logic [DATA_W-1:0] add_in2;
  logic [DATA_W-1:0] add_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_sum;
  logic [TAG_W-1:0]  rsp_tag;
  logic              busy;

  // Parent side: issues requests, owns the adder, consumes responses.
  modport master (
    output req_valid, req_a, req_b, req_tag, add_out, rsp_ready,
    input  req_ready, add_in1, add_in2, rsp_valid, rsp_sum, rsp_tag, busy
  );

  // Control stage side.
  modport slave (
    input  req_valid, req_a, req_b, req_tag, add_out, rsp_ready,
    output req_ready, add_in1, add_in2, rsp_valid, rsp_sum, rsp_tag, busy
  );

endinterface

// File: rtl/adder_rsp_fifo.sv
// Synchronous circular FIFO with extra-MSB pointers and a combinational head read.
module adder_rsp_fifo
  import adder_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = rsp_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t wr_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        mem [DEPTH];
  logic          do_pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head   = mem[rd_ptr[AW-1:0]];
  assign do_pop = pop & ~empty;

  // Storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/adder_issue_ctrl.sv
// Issue/response control around a non-stallable pipelined adder: operand drive,
// valid/tag tracking, credit-based admission and an in-order response FIFO.
module adder_issue_ctrl
  import adder_issue_ctrl_pkg::*;
#(
  parameter int unsigned ADD_LAT    = ADD_LAT_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = TAG_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  adder_issue_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic               acc;
  logic               pop;
  logic               push;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               ready_q;
  logic               busy_q;
  logic [ADD_LAT-1:0] vld_sr;
  logic [TAG_W-1:0]   tag_sr [ADD_LAT];
  entry_t             wr_entry;
  entry_t             head;
  logic               full;
  logic               empty;

  assign acc  = bus.req_valid & ready_q;
  assign pop  = ~empty & bus.rsp_ready;
  assign push = vld_sr[ADD_LAT-1];

  // Operands are zeroed when nothing is issued to keep the adder quiet.
  assign bus.add_in1 = acc ? bus.req_a : '0;
  assign bus.add_in2 = acc ? bus.req_b : '0;

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = ~empty;
  assign bus.rsp_sum   = head.sum;
  assign bus.rsp_tag   = head.tag;

  assign wr_entry = '{sum: bus.add_out, tag: tag_sr[ADD_LAT-1]};

  // Credits cover results in the adder plus entries held in the FIFO.
  always_comb begin
    cnt_nxt = cnt;
    if (acc && !pop) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (!acc && pop) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // Ready and busy are registered images of the next credit count.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      ready_q <= (cnt_nxt < CNT_W'(FIFO_DEPTH));
      busy_q  <= (cnt_nxt != '0);
    end
  end

  // Valid/tag shadow of the adder pipeline.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld_sr <= '0;
      for (int unsigned i = 0; i < ADD_LAT; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= acc;
      tag_sr[0] <= bus.req_tag;
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  adder_rsp_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // The credit scheme must make both of these unreachable.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst_n) !(push && full));
  a_cnt_bound:    assert property (@(posedge clk) disable iff (rst_n) cnt <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Bench for adder_issue_ctrl: a two-stage adder model plus a queue-based response model.
module tb_adder_issue_ctrl;
  import adder_issue_ctrl_pkg::*;

  localparam int unsigned TW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;

  typedef struct {
    logic [31:0]   sum;
    logic [TW-1:0] tag;
    int            t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] add_p1;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   armed  = 1'b0;
  exp_t q[$];

  adder_issue_ctrl_if #(.TAG_W(TW)) bus ();

  always #5 clk = ~clk;

  // Two-stage adder as the parent would hook it up, sharing the reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      add_p1      <= '0;
      bus.add_out <= '0;
    end else begin
      add_p1      <= bus.add_in1 + bus.add_in2;
      bus.add_out <= add_p1;
    end
  end

  adder_issue_ctrl #(.ADD_LAT(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // A result is visible once it has been accepted LAT edges ago.
  function automatic bit exp_valid();
    return (q.size() > 0) && (cyc >= q[0].t + int'(LAT));
  endfunction

  function automatic bit exp_ready();
    return armed && (q.size() < int'(DEPTH));
  endfunction

  // Apply inputs at a negedge, advance one edge, update the model, return at the next negedge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] tag, input bit rr, output bit accepted);
    bit popped;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    bus.rsp_ready = rr;
    accepted = v && exp_ready();
    popped   = rr && exp_valid();
    @(posedge clk);
    cyc++;
    if (!rst_n) armed = 1'b1;
    if (popped) void'(q.pop_front());
    if (accepted) q.push_back('{sum: a + b, tag: tag, t: cyc});
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit acc;
    rst_n = 1'b1;
    bus.req_valid = 1'b1; bus.req_a = 32'hDEAD_BEEF; bus.req_b = 32'h1;
    bus.req_tag = '1; bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.rsp_sum !== 32'h0 || bus.rsp_tag !== '0) begin errors++; $display("FAIL rst_head got=%h/%h exp=0/0", bus.rsp_sum, bus.rsp_tag); end
    checks++; if (bus.add_in1 !== 32'h0 || bus.add_in2 !== 32'h0) begin errors++; $display("FAIL rst_add_in got=%h/%h exp=0/0", bus.add_in1, bus.add_in2); end
    rst_n = 1'b0; q.delete(); armed = 1'b0;
    step(1'b0, 32'h0, 32'h0, '0, 1'b0, acc);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_single_op();
    bit acc;
    bus.req_valid = 1'b1; bus.req_a = 32'h0000_FFFF; bus.req_b = 32'h1; bus.req_tag = 4'd3; bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.add_in1 !== 32'h0000_FFFF || bus.add_in2 !== 32'h1) begin errors++; $display("FAIL single_add_in got=%h/%h exp=0000ffff/00000001", bus.add_in1, bus.add_in2); end
    step(1'b1, 32'h0000_FFFF, 32'h1, 4'd3, 1'b0, acc);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    step(1'b0, 32'h0, 32'h0, '0, 1'b0, acc);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_lat2 got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.add_in1 !== 32'h0) begin errors++; $display("FAIL idle_add_in1 got=%h exp=0", bus.add_in1); end
    step(1'b0, 32'h0, 32'h0, '0, 1'b0, acc);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_lat3 got=%b exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 32'h0001_0000 || bus.rsp_tag !== 4'd3) begin errors++; $display("FAIL single_result got=%h/%0d exp=00010000/3", bus.rsp_sum, bus.rsp_tag); end
    step(1'b0, 32'h0, 32'h0, '0, 1'b1, acc);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_drain got=%b/%b exp=0/0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_wrap();
    bit acc;
    step(1'b1, 32'hFFFF_FFFF, 32'h1, 4'd5, 1'b0, acc);
    step(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd6, 1'b0, acc);
    step(1'b0, 32'h0, 32'h0, '0, 1'b0, acc);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h0 || bus.rsp_tag !== 4'd5) begin errors++; $display("FAIL wrap_first got=%b/%h/%0d exp=1/00000000/5", bus.rsp_valid, bus.rsp_sum, bus.rsp_tag); end
    step(1'b0, 32'h0, 32'h0, '0, 1'b1, acc);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h0 || bus.rsp_tag !== 4'd6) begin errors++; $display("FAIL wrap_second got=%b/%h/%0d exp=1/00000000/6", bus.rsp_valid, bus.rsp_sum, bus.rsp_tag); end
    step(1'b0, 32'h0, 32'h0, '0, 1'b1, acc);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_backpressure();
    bit acc;
    int n_acc = 0, n_pop = 0, first_pop = -1, acc5 = -1;
    for (int i = 0; i < 30; i++) begin
      bit rr = (i >= 10);
      bit v  = (n_acc < 5);
      checks++; if (bus.rsp_valid !== exp_valid()) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_valid()); end
      checks++; if (bus.req_ready !== exp_ready()) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready()); end
      if (i == 8) begin
        checks++; if (bus.add_in1 !== 32'h0) begin errors++; $display("FAIL bp_stall_operand got=%h exp=0", bus.add_in1); end
      end
      if (bus.rsp_valid && rr) begin
        checks++; if (bus.rsp_tag !== 4'(n_pop)) begin errors++; $display("FAIL bp_order got=%0d exp=%0d", bus.rsp_tag, n_pop); end
        if (first_pop < 0) first_pop = cyc + 1;
        n_pop++;
      end
      step(v, $urandom, $urandom, 4'(n_acc), rr, acc);
      if (acc) begin
        if (n_acc == 4) acc5 = cyc;
        n_acc++;
        if (n_acc == 4) begin
          checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_fall got=%b exp=0", bus.req_ready); end
        end
      end
    end
    checks++; if (acc5 !== first_pop + 1) begin errors++; $display("FAIL bp_fifth_accept got=%0d exp=%0d", acc5, first_pop + 1); end
    checks++; if (n_pop !== 5) begin errors++; $display("FAIL bp_pop_count got=%0d exp=5", n_pop); end
  endtask

  task automatic test_streaming();
    bit acc;
    int k = 0;
    for (int i = 0; i < 20; i++) begin
      bit v = (i < 16);
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_sum !== 32'(k) * 32'h0001_0001) begin errors++; $display("FAIL stream_sum k=%0d got=%h exp=%h", k, bus.rsp_sum, 32'(k) * 32'h0001_0001); end
        k++;
      end
      if (v) begin
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, bus.req_ready); end
      end
      step(v, 32'(i), 32'(i) << 16, 4'(i), 1'b1, acc);
      checks++; if (bus.rsp_valid !== (i >= 2 && i <= 17)) begin errors++; $display("FAIL stream_valid i=%0d got=%b exp=%b", i, bus.rsp_valid, (i >= 2 && i <= 17)); end
    end
    checks++; if (k !== 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", k); end
  endtask

  task automatic test_full_toggle();
    bit acc;
    int nt = 0, exp_tag = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, $urandom, $urandom, 4'(nt), 1'b0, acc);
      if (acc) nt++;
    end
    checks++; if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL full_fill got=%b/%b exp=0/1", bus.req_ready, bus.busy); end
    for (int i = 0; i < 52; i++) begin
      bit rr = (i >= 40) ? 1'b1 : bit'(i % 2);
      bit v  = (i < 30);
      checks++; if (bus.req_ready !== exp_ready()) begin errors++; $display("FAIL full_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready()); end
      checks++; if (bus.rsp_valid !== exp_valid()) begin errors++; $display("FAIL full_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_valid()); end
      if (exp_valid()) begin
        checks++; if (bus.rsp_sum !== q[0].sum) begin errors++; $display("FAIL full_sum cyc=%0d got=%h exp=%h", cyc, bus.rsp_sum, q[0].sum); end
      end
      if (bus.rsp_valid && rr) begin
        checks++; if (bus.rsp_tag !== 4'(exp_tag)) begin errors++; $display("FAIL full_order got=%0d exp=%0d", bus.rsp_tag, 4'(exp_tag)); end
        exp_tag++;
      end
      step(v, $urandom, $urandom, 4'(nt), rr, acc);
      if (acc) nt++;
    end
    checks++; if (exp_tag !== nt || bus.busy !== 1'b0) begin errors++; $display("FAIL full_drain got=%0d/%b exp=%0d/0", exp_tag, bus.busy, nt); end
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 240; i++) begin
      bit v  = (i < 220) && ($urandom_range(0, 1) == 1);
      bit rr = (i >= 220) || ($urandom_range(0, 3) != 0);
      checks++; if (bus.req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready()); end
      checks++; if (bus.rsp_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_valid()); end
      checks++; if (bus.busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, q.size() != 0); end
      if (exp_valid()) begin
        checks++; if (bus.rsp_sum !== q[0].sum || bus.rsp_tag !== q[0].tag) begin errors++; $display("FAIL rnd_head cyc=%0d got=%h/%0d exp=%h/%0d", cyc, bus.rsp_sum, bus.rsp_tag, q[0].sum, q[0].tag); end
      end
      step(v, $urandom, $urandom, 4'($urandom), rr, acc);
    end
  endtask

  task automatic test_reset_mid_op();
    bit acc;
    for (int i = 1; i <= 3; i++) step(1'b1, $urandom, $urandom, 4'(i), 1'b0, acc);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b/%b exp=1/1", bus.rsp_valid, bus.busy); end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL midrst_during got=%b/%b/%b exp=0/0/0", bus.rsp_valid, bus.busy, bus.req_ready); end
    checks++; if (bus.rsp_sum !== 32'h0) begin errors++; $display("FAIL midrst_sum got=%h exp=0", bus.rsp_sum); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; q.delete(); armed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 32'h0, '0, 1'b1, acc);
      checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_stale i=%0d got=%b/%b exp=0/0", i, bus.rsp_valid, bus.busy); end
    end
    step(1'b1, 32'd5, 32'd7, 4'd9, 1'b0, acc);
    step(1'b0, 32'h0, 32'h0, '0, 1'b0, acc);
    step(1'b0, 32'h0, 32'h0, '0, 1'b0, acc);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'd12 || bus.rsp_tag !== 4'd9) begin errors++; $display("FAIL midrst_new got=%b/%0d/%0d exp=1/12/9", bus.rsp_valid, bus.rsp_sum, bus.rsp_tag); end
    step(1'b0, 32'h0, 32'h0, '0, 1'b1, acc);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_wrap();
    test_backpressure();
    test_streaming();
    test_full_toggle();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
